// File: rtl/p1bs_seq_pkg.sv
// Shared state codes, widths and small helpers for the P1BS lock sequencer.
// The state encoding is also exported on the state port, so the codes are fixed.
package p1bs_seq_pkg;

    localparam int STATE_W = 3;
    localparam int GAIN_W  = 10;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_RAMP   = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOCKED = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLD   = 3'd3;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

    typedef struct packed {
        logic on;
        logic hold;
        logic locked;
        logic fault;
    } ctrl_t;

    // Filter control pins implied by a given state.
    function automatic ctrl_t decode_ctrl(input logic [STATE_W-1:0] st);
        ctrl_t c;
        c = '{on: 1'b0, hold: 1'b0, locked: 1'b0, fault: 1'b0};
        case (st)
            ST_RAMP:   c.on = 1'b1;
            ST_LOCKED: begin
                c.on     = 1'b1;
                c.locked = 1'b1;
            end
            ST_HOLD:   begin
                c.on   = 1'b1;
                c.hold = 1'b1;
            end
            ST_FAULT:  c.fault = 1'b1;
            default:   c = '{on: 1'b0, hold: 1'b0, locked: 1'b0, fault: 1'b0};
        endcase
        return c;
    endfunction

    // Rail monitoring only runs while the filter is ramping or locked.
    function automatic logic is_rail_state(input logic [STATE_W-1:0] st);
        return (st == ST_RAMP) || (st == ST_LOCKED);
    endfunction

endpackage

// File: rtl/p1bs_gain_ramp.sv
// Rate divider plus one-LSB NP stepper; walks NP toward the live target without
// overshoot. The divider only advances while NP is away from the target.
module p1bs_gain_ramp
    import p1bs_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [GAIN_W-1:0] start,
    input  logic signed [GAIN_W-1:0] tgt,
    input  logic [DIV_W-1:0]         div,
    input  logic                     run,
    output logic signed [GAIN_W-1:0] NP,
    output logic                     at_tgt
);

    logic signed [GAIN_W-1:0] np_r;
    logic [DIV_W-1:0]         div_cnt_r;
    logic                     at_tgt_s;
    logic                     div_tc_s;

    assign at_tgt_s = (np_r == tgt);
    // div can be lowered live, so treat anything at or past it as terminal
    assign div_tc_s = (div_cnt_r >= div);
    assign at_tgt   = at_tgt_s;
    assign NP       = np_r;

    // Divider and gain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_r      <= 10'sd0;
            div_cnt_r <= '0;
        end else if (load) begin
            np_r      <= start;
            div_cnt_r <= '0;
        end else if (run && !at_tgt_s) begin
            if (div_tc_s) begin
                div_cnt_r <= '0;
                np_r      <= (np_r < tgt) ? (np_r + 10'sd1) : (np_r - 10'sd1);
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end else begin
            np_r      <= np_r;
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule

// File: rtl/p1bs_lock_seq.sv
// Lock sequencer for one P1BS channel: ramps NP to target, watches for rail
// saturation and runs bounded hold/clear/re-ramp recovery before faulting.
module p1bs_lock_seq
    import p1bs_seq_pkg::*;
#(
    parameter int SIGNAL_SIZE = 25,
    parameter int DIV_W       = 16,
    parameter int RAIL_CNT    = 1024,
    parameter int HOLD_CYC    = 4096,
    parameter int MAX_RETRY   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic signed [9:0]             NP_start,
    input  logic signed [9:0]             NP_tgt,
    input  logic signed [9:0]             NF_set,
    input  logic [DIV_W-1:0]              ramp_div,
    input  logic signed [SIGNAL_SIZE-1:0] s_out,
    input  logic signed [SIGNAL_SIZE-1:0] LL,
    input  logic signed [SIGNAL_SIZE-1:0] UL,
    output logic                          on,
    output logic                          hold,
    output logic signed [9:0]             NP,
    output logic signed [9:0]             NF,
    output logic [2:0]                    state,
    output logic                          locked,
    output logic                          fault,
    output logic [1:0]                    retry_cnt
);

    localparam int RAIL_W = $clog2(RAIL_CNT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] next_s;
    logic [RAIL_W-1:0]  rail_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [1:0]         retry_r;
    logic signed [9:0]  nf_r;
    ctrl_t              ctrl_r;
    ctrl_t              ctrl_next_s;

    logic railed_s;
    logic rail_hit_s;
    logic hold_done_s;
    logic at_tgt_s;
    logic load_s;
    logic run_s;

    assign railed_s    = (s_out >= UL) || (s_out <= LL);
    assign rail_hit_s  = is_rail_state(state_r) && railed_s &&
                         (rail_cnt_r == RAIL_W'(RAIL_CNT - 1));
    assign hold_done_s = (hold_cnt_r == HOLD_W'(HOLD_CYC - 1));

    // Next-state selection; en low overrides everything.
    always_comb begin
        next_s = state_r;
        if (!en) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_s = ST_RAMP;
                ST_RAMP: begin
                    if (rail_hit_s) begin
                        next_s = ST_HOLD;
                    end else if (at_tgt_s) begin
                        next_s = ST_LOCKED;
                    end else begin
                        next_s = ST_RAMP;
                    end
                end
                ST_LOCKED: begin
                    if (rail_hit_s) begin
                        next_s = ST_HOLD;
                    end else if (!at_tgt_s) begin
                        next_s = ST_RAMP;
                    end else begin
                        next_s = ST_LOCKED;
                    end
                end
                ST_HOLD: begin
                    if (hold_done_s) begin
                        next_s = ST_CLEAR;
                    end else begin
                        next_s = ST_HOLD;
                    end
                end
                ST_CLEAR: begin
                    if (retry_r == 2'(MAX_RETRY)) begin
                        next_s = ST_FAULT;
                    end else begin
                        next_s = ST_RAMP;
                    end
                end
                ST_FAULT:  next_s = ST_FAULT;
                default:   next_s = ST_IDLE;
            endcase
        end
    end

    // NP is reloaded while idle and on entry to CLEAR so CLEAR already shows NP_start.
    assign load_s      = (state_r == ST_IDLE) || (next_s == ST_IDLE) || (next_s == ST_CLEAR);
    assign run_s       = (state_r == ST_RAMP) && (next_s != ST_HOLD);
    assign ctrl_next_s = decode_ctrl(next_s);

    p1bs_gain_ramp #(
        .DIV_W (DIV_W)
    ) u_gain_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .start  (NP_start),
        .tgt    (NP_tgt),
        .div    (ramp_div),
        .run    (run_s),
        .NP     (NP),
        .at_tgt (at_tgt_s)
    );

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ctrl_r  <= '{on: 1'b0, hold: 1'b0, locked: 1'b0, fault: 1'b0};
            nf_r    <= 10'sd0;
        end else begin
            state_r <= next_s;
            ctrl_r  <= ctrl_next_s;
            nf_r    <= NF_set;
        end
    end

    // Consecutive-rail counter; any clean sample or leaving RAMP/LOCKED restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rail_cnt_r <= '0;
        end else if (!is_rail_state(state_r) || !railed_s || rail_hit_s) begin
            rail_cnt_r <= '0;
        end else begin
            rail_cnt_r <= rail_cnt_r + RAIL_W'(1);
        end
    end

    // HOLD dwell timer, zero on HOLD entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= '0;
        end else if ((state_r == ST_HOLD) && !hold_done_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= '0;
        end
    end

    // Recovery counter, saturating; cleared whenever the sequencer lands in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_r <= 2'd0;
        end else if (next_s == ST_IDLE) begin
            retry_r <= 2'd0;
        end else if (rail_hit_s && (retry_r != 2'd3)) begin
            retry_r <= retry_r + 2'd1;
        end else begin
            retry_r <= retry_r;
        end
    end

    assign state     = state_r;
    assign on        = ctrl_r.on;
    assign hold      = ctrl_r.hold;
    assign locked    = ctrl_r.locked;
    assign fault     = ctrl_r.fault;
    assign retry_cnt = retry_r;
    assign NF        = nf_r;

endmodule

// File: tb/tb_p1bs_lock_seq.sv
// Directed bench for p1bs_lock_seq: ramp timing, rail recovery, fault path,
// target edge cases, abort and asynchronous reset.
module tb_p1bs_lock_seq;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic signed [9:0]  np_start;
    logic signed [9:0]  np_tgt;
    logic signed [9:0]  nf_set;
    logic [15:0]        ramp_div;
    logic signed [24:0] s_out;
    logic signed [24:0] ll;
    logic signed [24:0] ul;
    logic               on;
    logic               hold;
    logic signed [9:0]  np;
    logic signed [9:0]  nf;
    logic [2:0]         state;
    logic               locked;
    logic               fault;
    logic [1:0]         retry_cnt;

    int n_checks;
    int n_fail;

    p1bs_lock_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .NP_start  (np_start),
        .NP_tgt    (np_tgt),
        .NF_set    (nf_set),
        .ramp_div  (ramp_div),
        .s_out     (s_out),
        .LL        (ll),
        .UL        (ul),
        .on        (on),
        .hold      (hold),
        .NP        (np),
        .NF        (nf),
        .state     (state),
        .locked    (locked),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        np_start = -10'sd8;
        np_tgt   = 10'sd4;
        nf_set   = 10'sd37;
        ramp_div = 16'd9;
        s_out    = 25'sd0;
        ll       = -25'sd1000;
        ul       = 25'sd1000;
        #23;
        check_eq("rst_state", state, 0);
        check_eq("rst_on", on, 0);
        check_eq("rst_hold", hold, 0);
        check_eq("rst_np", np, 0);
        check_eq("rst_nf", nf, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_retry", retry_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // basic ramp -8 -> 4, one step per 10 cycles
        tick(1);
        check_eq("idle_state", state, 0);
        check_eq("idle_np", np, -8);
        check_eq("nf_pass", nf, 37);
        check_eq("idle_on", on, 0);
        en = 1'b1;
        tick(1);
        check_eq("ramp_state", state, 1);
        check_eq("ramp_on", on, 1);
        check_eq("ramp_np0", np, -8);
        tick(9);
        check_eq("ramp_np_pre", np, -8);
        tick(1);
        check_eq("ramp_np_step1", np, -7);
        tick(109);
        check_eq("ramp_np_3", np, 3);
        check_eq("ramp_still", state, 1);
        tick(1);
        check_eq("ramp_np_4", np, 4);
        check_eq("ramp_not_locked", locked, 0);
        tick(1);
        check_eq("locked_flag", locked, 1);
        check_eq("locked_state", state, 2);
        check_eq("locked_np", np, 4);

        // 1023 railed cycles then one clean sample must not trigger
        s_out = ul;
        tick(1023);
        check_eq("rail1023_state", state, 2);
        s_out = 25'sd0;
        tick(1);
        check_eq("rail_glitch_state", state, 2);

        // full rail on LL -> HOLD / CLEAR / RAMP
        s_out = ll;
        tick(1023);
        check_eq("rail_pre_state", state, 2);
        check_eq("rail_pre_hold", hold, 0);
        tick(1);
        check_eq("hold1_state", state, 3);
        check_eq("hold1_hold", hold, 1);
        check_eq("hold1_on", on, 1);
        check_eq("hold1_retry", retry_cnt, 1);
        tick(4095);
        check_eq("hold1_end_state", state, 3);
        check_eq("hold1_end_hold", hold, 1);
        tick(1);
        check_eq("clear1_state", state, 4);
        check_eq("clear1_on", on, 0);
        check_eq("clear1_hold", hold, 0);
        check_eq("clear1_np", np, -8);
        tick(1);
        check_eq("rerampl_state", state, 1);
        check_eq("reramp1_on", on, 1);
        check_eq("reramp1_retry", retry_cnt, 1);

        // s_out stays railed: two more recoveries, then FAULT
        tick(1023);
        check_eq("rail2_pre_state", state, 2);
        tick(1);
        check_eq("hold2_state", state, 3);
        check_eq("hold2_retry", retry_cnt, 2);
        tick(4096);
        check_eq("clear2_state", state, 4);
        tick(1);
        check_eq("reramp2_state", state, 1);
        tick(1024);
        check_eq("hold3_state", state, 3);
        check_eq("hold3_retry", retry_cnt, 3);
        tick(4096);
        check_eq("clear3_state", state, 4);
        check_eq("clear3_on", on, 0);
        tick(1);
        check_eq("fault_state", state, 5);
        check_eq("fault_flag", fault, 1);
        check_eq("fault_on", on, 0);
        check_eq("fault_hold", hold, 0);
        tick(5);
        check_eq("fault_sticky", state, 5);
        check_eq("fault_sticky_flag", fault, 1);
        en = 1'b0;
        tick(1);
        check_eq("fault_exit_state", state, 0);
        check_eq("fault_exit_retry", retry_cnt, 0);
        check_eq("fault_exit_flag", fault, 0);

        // NP_start == NP_tgt, then retarget while LOCKED
        s_out    = 25'sd0;
        np_start = 10'sd5;
        np_tgt   = 10'sd5;
        ramp_div = 16'd0;
        tick(1);
        check_eq("eq_idle_np", np, 5);
        en = 1'b1;
        tick(1);
        check_eq("eq_ramp_state", state, 1);
        check_eq("eq_ramp_locked", locked, 0);
        tick(1);
        check_eq("eq_locked_state", state, 2);
        check_eq("eq_locked_flag", locked, 1);
        np_tgt = 10'sd6;
        tick(1);
        check_eq("retgt_state", state, 1);
        check_eq("retgt_np", np, 5);
        check_eq("retgt_locked", locked, 0);
        tick(1);
        check_eq("retgt_np6", np, 6);
        tick(1);
        check_eq("retgt_locked_state", state, 2);
        check_eq("retgt_locked_np", np, 6);

        // descending ramp 10 -> 2 at one step per cycle
        en       = 1'b0;
        np_start = 10'sd10;
        np_tgt   = 10'sd2;
        tick(1);
        check_eq("dn_idle_np", np, 10);
        en = 1'b1;
        tick(1);
        check_eq("dn_ramp_np", np, 10);
        tick(1);
        check_eq("dn_np9", np, 9);
        tick(7);
        check_eq("dn_np2", np, 2);
        check_eq("dn_np2_state", state, 1);
        tick(1);
        check_eq("dn_locked", state, 2);
        tick(3);
        check_eq("dn_no_undershoot", np, 2);

        // abort mid-HOLD
        s_out = ul;
        tick(1024);
        check_eq("abort_hold_state", state, 3);
        check_eq("abort_hold_flag", hold, 1);
        tick(100);
        en = 1'b0;
        tick(1);
        check_eq("abort_state", state, 0);
        check_eq("abort_on", on, 0);
        check_eq("abort_hold", hold, 0);

        // asynchronous reset mid-RAMP, restart from IDLE
        s_out    = 25'sd0;
        np_start = -10'sd8;
        np_tgt   = 10'sd4;
        ramp_div = 16'd9;
        tick(1);
        en = 1'b1;
        tick(1);
        check_eq("pre_rst_state", state, 1);
        tick(5);
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", state, 0);
        check_eq("arst_on", on, 0);
        check_eq("arst_np", np, 0);
        check_eq("arst_nf", nf, 0);
        check_eq("arst_locked", locked, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        check_eq("restart_state", state, 1);
        check_eq("restart_np", np, -8);
        check_eq("restart_on", on, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
